t09_obstacle_scanner: RTL and testbench
=======================================

// Module: t09_obstacle_scanner
// PURPOSE
//   Reader side of the obstacle map. On a start pulse it walks every grid cell
//   row-major through the obstacle generator's (x,y) query port. Each occupied
//   cell is emitted as one coordinate beat on a valid/ready stream, which feeds
//   the display/sprite driver. One scan visits the whole playfield once.
// PARAMETERS
//   GRID_W  14  columns; x runs 1..GRID_W
//   GRID_H  10  rows; y runs 1..GRID_H
// PORTS
//   clk        in   1  system clock, all state on rising edge
//   rst        in   1  asynchronous, active-high reset
//   s_reset    in   1  synchronous game reset; aborts any scan
//   start      in   1  1-cycle request; begin a scan (sampled in IDLE only)
//   qx         out  4  query x to generator's x input
//   qy         out  4  query y to generator's y input
//   obstacle   in   1  generator's combinational answer for (qx,qy)
//   out_valid  out  1  out_x/out_y hold an occupied cell
//   out_ready  in   1  consumer accepts the beat when high with out_valid
//   out_x      out  4  occupied cell x
//   out_y      out  4  occupied cell y
//   busy       out  1  high in SCAN/EMIT/DONE
//   done       out  1  1-cycle pulse at scan completion
//   count      out  8  occupied cells emitted in current/last scan
// BEHAVIOUR
//   Reset (rst=1, immediate): state=IDLE, qx=1, qy=1, out_valid=0, out_x=0,
//     out_y=0, busy=0, done=0, count=0.
//   FSM states: IDLE, SCAN, EMIT, DONE. All outputs are registered.
//   IDLE:
//     - start=1 -> SCAN; qx=1, qy=1, count=0.
//     - Otherwise hold. qx/qy keep their last value.
//   SCAN (one cell per cycle):
//     - obstacle is sampled against the current qx/qy.
//     - obstacle=1 -> EMIT; out_x=qx, out_y=qy, out_valid=1.
//     - obstacle=0 and cell is not last -> advance: qx+1; at qx=GRID_W wrap
//       to qx=1 and qy+1.
//     - obstacle=0 and cell is last (GRID_W,GRID_H) -> DONE.
//   EMIT:
//     - out_valid=1. out_x/out_y are held stable until the handshake.
//     - out_ready=1 -> out_valid=0, count+1 (saturating at 255). Then advance
//       as in SCAN and return to SCAN, or go to DONE if this was the last cell.
//     - out_ready=0 -> stay in EMIT (unbounded backpressure allowed).
//   DONE:
//     - done=1 for exactly one cycle -> IDLE. count holds until the next start.
//   Timing:
//     - With out_ready tied high, a scan takes GRID_W*GRID_H + k cycles
//       (k = occupied cells), plus 1 DONE cycle.
//     - Start sampled at edge 0: first query (1,1) is at cycle 1. On an empty
//       grid done is high in cycle 141.
//   Boundary cases:
//     - start while busy: ignored.
//     - start and s_reset together: s_reset wins.
//     - s_reset=1 in any state -> next cycle is IDLE, out_valid=0, busy=0,
//       done=0, count=0, qx=qy=1. A pending beat is dropped.
//     - rst mid-EMIT: out_valid drops immediately; no beat completes.
//     - qx/qy never leave 1..GRID_W / 1..GRID_H, so the generator index
//       x+(y-1)*14 stays in 1..140.
//     - The map is allowed to change during a scan. Each cell reflects the map
//       at the cycle it was queried.
// TESTING
//   1. Empty map, out_ready=1, pulse start -> no out_valid; done in cycle 141;
//      count=0.
//   2. Single obstacle at (3,2), out_ready=1 -> one beat out_x=3, out_y=2;
//      done in cycle 142; count=1.
//   3. Obstacles at (1,1) and (14,10), out_ready held low 5 cycles per beat
//      -> beats in order (1,1) then (14,10); out_x/out_y stable while
//      stalled; DONE entered straight from EMIT of the last cell; count=2.
//   4. Scan started, s_reset at cycle 20 -> IDLE next cycle, busy=0,
//      count=0, no done pulse; a new start rescans from (1,1).
//   5. start pulsed again at cycle 50 of a scan -> ignored; exactly one done
//      pulse; scan order unchanged.
//   6. rst asserted while out_valid=1 at (7,5) -> out_valid=0, busy=0,
//      count=0 asynchronously; after release the block idles until start.

Source files
------------

// File: rtl/t09_obstacle_scanner.sv
// Obstacle map reader: walks the playfield row-major through the generator's
// (x,y) query port and streams every occupied cell out on a valid/ready channel.
module t09_obstacle_scanner #(
  parameter int GRID_W = 14,
  parameter int GRID_H = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_reset,
  input  logic       start,
  output logic [3:0] qx,
  output logic [3:0] qy,
  input  logic       obstacle,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_x,
  output logic [3:0] out_y,
  output logic       busy,
  output logic       done,
  output logic [7:0] count
);

  localparam logic [3:0] LAST_X = 4'(GRID_W);
  localparam logic [3:0] LAST_Y = 4'(GRID_H);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t     state_r;
  logic       last_cell_s;
  logic [3:0] next_qx_s;
  logic [3:0] next_qy_s;
  logic [7:0] count_inc_s;

  // Next query position in row-major order and saturating beat count.
  always_comb begin
    last_cell_s = (qx == LAST_X) && (qy == LAST_Y);
    next_qx_s   = qx;
    next_qy_s   = qy;
    if (qx == LAST_X) begin
      next_qx_s = 4'd1;
      next_qy_s = qy + 4'd1;
    end else begin
      next_qx_s = qx + 4'd1;
      next_qy_s = qy;
    end
    if (count == 8'hFF) begin
      count_inc_s = count;
    end else begin
      count_inc_s = count + 8'd1;
    end
  end

  // Scanner FSM; every output is a register updated here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      qx        <= 4'd1;
      qy        <= 4'd1;
      out_valid <= 1'b0;
      out_x     <= 4'd0;
      out_y     <= 4'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      count     <= 8'd0;
    end else if (s_reset) begin
      state_r   <= IDLE;
      qx        <= 4'd1;
      qy        <= 4'd1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      count     <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state_r <= SCAN;
            qx      <= 4'd1;
            qy      <= 4'd1;
            count   <= 8'd0;
            busy    <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        SCAN: begin
          if (obstacle) begin
            state_r   <= EMIT;
            out_x     <= qx;
            out_y     <= qy;
            out_valid <= 1'b1;
          end else if (last_cell_s) begin
            state_r <= DONE;
            done    <= 1'b1;
          end else begin
            qx <= next_qx_s;
            qy <= next_qy_s;
          end
        end
        EMIT: begin
          // The query port stays parked on the emitted cell until the beat is taken.
          if (out_ready) begin
            out_valid <= 1'b0;
            count     <= count_inc_s;
            if (last_cell_s) begin
              state_r <= DONE;
              done    <= 1'b1;
            end else begin
              state_r <= SCAN;
              qx      <= next_qx_s;
              qy      <= next_qy_s;
            end
          end else begin
            state_r <= EMIT;
          end
        end
        DONE: begin
          state_r <= IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          state_r   <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_t09_obstacle_scanner.sv
// Directed bench for t09_obstacle_scanner: a bit-map model answers the query
// port and each scenario task checks its own expectations inline.
module tb_t09_obstacle_scanner;

  logic       clk = 1'b0;
  logic       rst, s_reset, start, obstacle, out_ready;
  logic       out_valid, busy, done;
  logic [3:0] qx, qy, out_x, out_y;
  logic [7:0] count;

  bit map [0:15][0:15];
  int tests = 0;
  int fails = 0;
  int cyc;
  int bx[$];
  int by[$];

  always #5 clk = ~clk;

  assign obstacle = map[qx][qy];

  t09_obstacle_scanner dut (
    .clk(clk), .rst(rst), .s_reset(s_reset), .start(start),
    .qx(qx), .qy(qy), .obstacle(obstacle),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y),
    .busy(busy), .done(done), .count(count)
  );

  task clear_map;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        map[i][j] = 1'b0;
  endtask

  // Pulses start, then runs until the block is idle again, holding each beat
  // for 'stall' cycles before accepting it; optionally re-pulses start.
  task run_scan(input int stall, input int restart_cyc, output int done_cyc,
                output int ndone, output int unstable, output bit timeout);
    bit in_beat;
    int w;
    logic [3:0] hx, hy;
    bx.delete(); by.delete();
    done_cyc = -1; ndone = 0; unstable = 0; timeout = 1'b1;
    in_beat = 1'b0; w = 0; hx = 4'd0; hy = 4'd0;
    @(negedge clk); start = 1'b1; out_ready = (stall == 0);
    @(negedge clk); start = 1'b0; cyc = 1;
    repeat (600) begin
      start = (cyc == restart_cyc);
      if (out_valid === 1'b1) begin
        if (!in_beat) begin
          in_beat = 1'b1; w = 0; hx = out_x; hy = out_y;
        end else if (out_x !== hx || out_y !== hy) begin
          unstable++;
        end
        if (w >= stall) begin
          out_ready = 1'b1;
          bx.push_back(int'(out_x)); by.push_back(int'(out_y));
          in_beat = 1'b0;
        end else begin
          out_ready = 1'b0;
          w++;
        end
      end else begin
        out_ready = (stall == 0);
      end
      if (done === 1'b1) begin
        ndone++; done_cyc = cyc;
      end else if (ndone > 0 && busy === 1'b0) begin
        timeout = 1'b0;
        break;
      end
      @(negedge clk); cyc++;
    end
    start = 1'b0; out_ready = 1'b0;
  endtask

  task test_reset;
    rst = 1'b1; s_reset = 1'b0; start = 1'b0; out_ready = 1'b0;
    clear_map();
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    tests++; if (qx !== 4'd1) begin fails++; $display("FAIL reset_qx got %0d want 1", qx); end
    tests++; if (qy !== 4'd1) begin fails++; $display("FAIL reset_qy got %0d want 1", qy); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", out_valid); end
    tests++; if (out_x !== 4'd0 || out_y !== 4'd0) begin fails++; $display("FAIL reset_xy got %0d,%0d want 0,0", out_x, out_y); end
    tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL reset_busy_done got %b%b want 00", busy, done); end
    tests++; if (count !== 8'd0) begin fails++; $display("FAIL reset_count got %0d want 0", count); end
  endtask

  task test_empty;
    int dc, nd, un; bit to;
    clear_map();
    run_scan(0, -1, dc, nd, un, to);
    tests++; if (to !== 1'b0) begin fails++; $display("FAIL empty_timeout scan did not finish"); end
    tests++; if (nd !== 1) begin fails++; $display("FAIL empty_ndone got %0d want 1", nd); end
    tests++; if (dc !== 141) begin fails++; $display("FAIL empty_done_cycle got %0d want 141", dc); end
    tests++; if (bx.size() !== 0) begin fails++; $display("FAIL empty_beats got %0d want 0", bx.size()); end
    tests++; if (count !== 8'd0) begin fails++; $display("FAIL empty_count got %0d want 0", count); end
  endtask

  task test_single;
    int dc, nd, un; bit to;
    clear_map(); map[3][2] = 1'b1;
    run_scan(0, -1, dc, nd, un, to);
    tests++; if (to !== 1'b0 || nd !== 1) begin fails++; $display("FAIL single_done got ndone=%0d timeout=%0d want 1,0", nd, to); end
    tests++; if (dc !== 142) begin fails++; $display("FAIL single_done_cycle got %0d want 142", dc); end
    tests++; if (bx.size() !== 1 || bx[0] !== 3 || by[0] !== 2) begin fails++; $display("FAIL single_beat got n=%0d want one beat (3,2)", bx.size()); end
    tests++; if (count !== 8'd1) begin fails++; $display("FAIL single_count got %0d want 1", count); end
  endtask

  task test_backpressure;
    int dc, nd, un; bit to;
    clear_map(); map[1][1] = 1'b1; map[14][10] = 1'b1;
    run_scan(5, -1, dc, nd, un, to);
    tests++; if (to !== 1'b0 || nd !== 1) begin fails++; $display("FAIL bp_done got ndone=%0d timeout=%0d want 1,0", nd, to); end
    tests++; if (dc !== 153) begin fails++; $display("FAIL bp_done_cycle got %0d want 153", dc); end
    tests++; if (bx.size() !== 2) begin fails++; $display("FAIL bp_beats got %0d want 2", bx.size()); end
    tests++; if (bx.size() == 2 && (bx[0] !== 1 || by[0] !== 1 || bx[1] !== 14 || by[1] !== 10)) begin
      fails++; $display("FAIL bp_order got (%0d,%0d)(%0d,%0d) want (1,1)(14,10)", bx[0], by[0], bx[1], by[1]);
    end
    tests++; if (un !== 0) begin fails++; $display("FAIL bp_stable got %0d changes want 0", un); end
    tests++; if (count !== 8'd2) begin fails++; $display("FAIL bp_count got %0d want 2", count); end
  endtask

  task test_soft_reset;
    int dc, nd, un; bit to; bit seen;
    clear_map(); map[2][1] = 1'b1; map[5][1] = 1'b1;
    out_ready = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; cyc = 1;
    while (cyc < 20) begin @(negedge clk); cyc++; end
    tests++; if (count !== 8'd2 || busy !== 1'b1) begin fails++; $display("FAIL srst_pre got count=%0d busy=%b want 2,1", count, busy); end
    s_reset = 1'b1;
    @(negedge clk); s_reset = 1'b0;
    tests++; if (busy !== 1'b0 || count !== 8'd0) begin fails++; $display("FAIL srst_state got busy=%b count=%0d want 0,0", busy, count); end
    tests++; if (qx !== 4'd1 || qy !== 4'd1 || out_valid !== 1'b0) begin fails++; $display("FAIL srst_q got (%0d,%0d) valid=%b want (1,1) 0", qx, qy, out_valid); end
    seen = 1'b0;
    repeat (5) begin
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL srst_quiet got activity after soft reset want none"); end
    start = 1'b1; s_reset = 1'b1;
    @(negedge clk); start = 1'b0; s_reset = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL srst_wins got busy=%b want 0", busy); end
    run_scan(0, -1, dc, nd, un, to);
    tests++; if (dc !== 143 || nd !== 1) begin fails++; $display("FAIL srst_rescan got done_cycle=%0d ndone=%0d want 143,1", dc, nd); end
    tests++; if (bx.size() !== 2 || bx[0] !== 2 || by[0] !== 1) begin fails++; $display("FAIL srst_first_beat got n=%0d want first (2,1)", bx.size()); end
  endtask

  task test_back_to_back;
    int dc, nd, un; bit to;
    clear_map(); map[3][2] = 1'b1;
    run_scan(0, 50, dc, nd, un, to);
    tests++; if (nd !== 1 || to !== 1'b0) begin fails++; $display("FAIL restart_ndone got %0d want 1", nd); end
    tests++; if (dc !== 142) begin fails++; $display("FAIL restart_done_cycle got %0d want 142", dc); end
    tests++; if (bx.size() !== 1 || bx[0] !== 3 || by[0] !== 2) begin fails++; $display("FAIL restart_beats got n=%0d want one beat (3,2)", bx.size()); end
  endtask

  task test_async_reset;
    bit found; bit seen;
    clear_map(); map[1][1] = 1'b1; map[7][5] = 1'b1;
    out_ready = 1'b1; found = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (300) begin
      if (out_valid === 1'b1 && out_x === 4'd7 && out_y === 4'd5) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    tests++; if (found !== 1'b1 || count !== 8'd1) begin fails++; $display("FAIL arst_reach got found=%0d count=%0d want 1,1", found, count); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests++; if (out_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL arst_immediate got valid=%b busy=%b want 0,0", out_valid, busy); end
    tests++; if (count !== 8'd0 || qx !== 4'd1) begin fails++; $display("FAIL arst_count got count=%0d qx=%0d want 0,1", count, qx); end
    @(negedge clk); rst = 1'b0; out_ready = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      if (busy !== 1'b0 || out_valid !== 1'b0 || count !== 8'd0) seen = 1'b1;
      @(negedge clk);
    end
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL arst_idle got activity without start want idle"); end
  endtask

  initial begin
    test_reset();
    test_empty();
    test_single();
    test_backpressure();
    test_soft_reset();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
